// File: rtl/log_drop_window_pkg.sv
// rtl/log_drop_window_pkg.sv - shared constants and reference shift function for log-drop weighting
package dmpvl_logdrop_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // floor(log2(t+1)); t+1 is formed in int so the oldest index never overflows
  function automatic int logdropShift(input int t);
    int v;
    int s;
    v = t + 1;
    s = 0;
    for (int i = 1; i < 31; i++) begin
      if ((v >> i) != 0) s = i;
    end
    return s;
  endfunction

endpackage

// File: rtl/log_drop_window_if.sv
// rtl/log_drop_window_if.sv - sample/weight bus between a driver and log_drop_window
interface log_drop_window_if #(
  parameter int DATA_W = 8,
  parameter int T_W    = 6
);
  logic              i_cg;
  logic [T_W-1:0]    i_t;
  logic [DATA_W-1:0] i_x;
  logic [DATA_W-1:0] o_y;

  modport master (output i_cg, i_t, i_x, input o_y);
  modport slave  (input i_cg, i_t, i_x, output o_y);
endinterface

// File: rtl/log_drop_window_shift.sv
// rtl/log_drop_window_shift.sv - structural log2 priority encoder and saturating barrel right-shifter
module log_drop_shift_c
  import dmpvl_logdrop_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int T_W    = 6
) (
  input  logic [T_W-1:0]    t,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);
  localparam int SW  = clog2(T_W + 1);
  localparam int NST = clog2(DATA_W);
  localparam int SHW = (SW > NST) ? SW : NST;

  logic [T_W:0]      tp1;
  logic [SHW-1:0]    s;
  logic [DATA_W-1:0] v;

  assign tp1 = {1'b0, t} + {{T_W{1'b0}}, 1'b1};

  // highest set bit wins
  always_comb begin
    s = '0;
    for (int i = 0; i <= T_W; i++) begin
      if (tp1[i]) s = SHW'(i);
    end
  end

  // any shift reaching DATA_W clears the sample instead of wrapping
  always_comb begin
    v = x;
    for (int k = 0; k < NST; k++) begin
      if (s[k]) v = v >> (1 << k);
    end
    if (int'(s) >= DATA_W) v = '0;
    y = v;
  end
endmodule

// File: rtl/log_drop_window.sv
// rtl/log_drop_window.sv - power-of-two window weighting of one sample stream, registered output
module log_drop_window
  import dmpvl_logdrop_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int WINLEN         = 64,
  parameter int ABSTRACT_MODEL = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  log_drop_window_if.slave bus
);
  localparam int T_W = clog2(WINLEN);

  if (DATA_W < 1 || WINLEN < 2 || (WINLEN & (WINLEN - 1)) != 0) begin : g_bad_param
    $error("log_drop_window: DATA_W must be >=1 and WINLEN a power of two >=2");
  end

  logic [DATA_W-1:0] y_d;
  logic [DATA_W-1:0] y_q;

  if (ABSTRACT_MODEL == 0) begin : g_struct
    log_drop_shift_c #(
      .DATA_W (DATA_W),
      .T_W    (T_W)
    ) u_shift (
      .t (bus.i_t),
      .x (bus.i_x),
      .y (y_d)
    );
  end else begin : g_beh
    int s_beh;
    logic [DATA_W-1:0] y_beh;

    // one-bit shifts repeated s times saturate to zero on their own
    always_comb begin
      s_beh = logdropShift(int'(bus.i_t));
      y_beh = bus.i_x;
      for (int k = 0; k < DATA_W; k++) begin
        if (k < s_beh) y_beh = y_beh >> 1;
      end
    end
    assign y_d = y_beh;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      y_q <= '0;
    end else if (bus.i_cg) begin
      y_q <= y_d;
    end
  end

  assign bus.o_y = y_q;
endmodule

// File: tb/tb_log_drop_window.sv
// tb/tb_log_drop_window.sv - self-checking bench for log_drop_window, two configs x two models
module tb_log_drop_window;
  import dmpvl_logdrop_pkg::*;

  logic       clk;
  logic       rst;
  logic       run;
  logic       cg_a;
  logic [5:0] t_a;
  logic [7:0] x_a;
  logic       cg_b;
  logic [3:0] t_b;
  logic [4:0] x_b;
  logic [7:0] exp_a;
  logic [4:0] exp_b;
  int         checks;
  int         errors;

  log_drop_window_if #(.DATA_W(8), .T_W(6)) if_a0 ();
  log_drop_window_if #(.DATA_W(8), .T_W(6)) if_a1 ();
  log_drop_window_if #(.DATA_W(5), .T_W(4)) if_b0 ();
  log_drop_window_if #(.DATA_W(5), .T_W(4)) if_b1 ();

  assign if_a0.i_cg = cg_a;
  assign if_a0.i_t  = t_a;
  assign if_a0.i_x  = x_a;
  assign if_a1.i_cg = cg_a;
  assign if_a1.i_t  = t_a;
  assign if_a1.i_x  = x_a;
  assign if_b0.i_cg = cg_b;
  assign if_b0.i_t  = t_b;
  assign if_b0.i_x  = x_b;
  assign if_b1.i_cg = cg_b;
  assign if_b1.i_t  = t_b;
  assign if_b1.i_x  = x_b;

  log_drop_window #(.DATA_W(8), .WINLEN(64), .ABSTRACT_MODEL(0)) u_a0 (.i_clk(clk), .i_rst(rst), .bus(if_a0.slave));
  log_drop_window #(.DATA_W(8), .WINLEN(64), .ABSTRACT_MODEL(1)) u_a1 (.i_clk(clk), .i_rst(rst), .bus(if_a1.slave));
  log_drop_window #(.DATA_W(5), .WINLEN(16), .ABSTRACT_MODEL(0)) u_b0 (.i_clk(clk), .i_rst(rst), .bus(if_b0.slave));
  log_drop_window #(.DATA_W(5), .WINLEN(16), .ABSTRACT_MODEL(1)) u_b1 (.i_clk(clk), .i_rst(rst), .bus(if_b1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // largest power of two not exceeding t+1
  function automatic int ref_shift(input int t);
    int p;
    p = 0;
    while ((2 ** (p + 1)) <= t + 1) p++;
    return p;
  endfunction

  function automatic int ref_y(input int t, input int x);
    return x / (2 ** ref_shift(t));
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_a <= '0;
      exp_b <= '0;
    end else begin
      if (cg_a) exp_a <= 8'(ref_y(int'(t_a), int'(x_a)));
      if (cg_b) exp_b <= 5'(ref_y(int'(t_b), int'(x_b)));
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("cyc_a0", int'(if_a0.o_y), int'(exp_a));
      chk("cyc_a1", int'(if_a1.o_y), int'(exp_a));
      chk("cyc_b0", int'(if_b0.o_y), int'(exp_b));
      chk("cyc_b1", int'(if_b1.o_y), int'(exp_b));
    end
  end

  task automatic lit_a(input int t, input int x, input int e);
    t_a  = 6'(t);
    x_a  = 8'(x);
    cg_a = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("lit_a0_t%0d", t), int'(if_a0.o_y), e);
    chk($sformatf("lit_a1_t%0d", t), int'(if_a1.o_y), e);
    chk($sformatf("model_a_t%0d", t), ref_y(t, x), e);
  endtask

  task automatic lit_b(input int t, input int x, input int e);
    t_b  = 4'(t);
    x_b  = 5'(x);
    cg_b = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("lit_b0_t%0d", t), int'(if_b0.o_y), e);
    chk($sformatf("lit_b1_t%0d", t), int'(if_b1.o_y), e);
    chk($sformatf("model_b_t%0d", t), ref_y(t, x), e);
  endtask

  initial begin
    int lt_a[7];
    int le_a[7];
    int lt_b[4];
    int le_b[4];
    lt_a = '{0, 1, 2, 3, 6, 7, 63};
    le_a = '{8'hFF, 8'h7F, 8'h7F, 8'h3F, 8'h3F, 8'h1F, 8'h03};
    lt_b = '{0, 7, 14, 15};
    le_b = '{5'h1F, 5'h03, 5'h03, 5'h01};
    checks = 0;
    errors = 0;
    run  = 1'b0;
    rst  = 1'b1;
    cg_a = 1'b1;
    cg_b = 1'b1;
    t_a  = '0;
    x_a  = '0;
    t_b  = '0;
    x_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a0", int'(if_a0.o_y), 0);
    chk("reset_a1", int'(if_a1.o_y), 0);
    chk("reset_b0", int'(if_b0.o_y), 0);
    chk("reset_b1", int'(if_b1.o_y), 0);
    rst = 1'b0;
    run = 1'b1;

    for (int i = 0; i < 7; i++) lit_a(lt_a[i], 8'hFF, le_a[i]);
    for (int i = 0; i < 4; i++) lit_b(lt_b[i], 5'h1F, le_b[i]);
    lit_b(15, 5'h0F, 0);

    // A holds 0x03 from t=63 while gated
    cg_a = 1'b0;
    t_a  = '0;
    x_a  = 8'h80;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_a0", int'(if_a0.o_y), 8'h03);
      chk("hold_a1", int'(if_a1.o_y), 8'h03);
    end
    cg_a = 1'b1;
    @(posedge clk);
    #1;
    chk("ungate_a0", int'(if_a0.o_y), 8'h80);
    chk("ungate_a1", int'(if_a1.o_y), 8'h80);

    for (int t = 0; t < 64; t++) begin
      chk($sformatf("pkg_shift_t%0d", t), logdropShift(t), ref_shift(t));
      for (int x = 0; x < 256; x++) begin
        int k;
        k    = (t * 256 + x) % 512;
        t_a  = 6'(t);
        x_a  = 8'(x);
        t_b  = 4'(k / 32);
        x_b  = 5'(k % 32);
        @(posedge clk);
        #1;
      end
    end

    for (int i = 0; i < 2000; i++) begin
      cg_a = 1'($urandom_range(0, 1));
      cg_b = 1'($urandom_range(0, 1));
      t_a  = 6'($urandom);
      x_a  = 8'($urandom);
      t_b  = 4'($urandom);
      x_b  = 5'($urandom);
      @(posedge clk);
      #1;
    end

    cg_a = 1'b1;
    t_a  = '0;
    x_a  = 8'hFF;
    @(posedge clk);
    #1;
    chk("pre_rst_a0", int'(if_a0.o_y), 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_a0", int'(if_a0.o_y), 0);
    chk("async_rst_a1", int'(if_a1.o_y), 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_a0", int'(if_a0.o_y), 0);
      chk("rst_hold_a1", int'(if_a1.o_y), 0);
    end
    rst = 1'b0;
    t_a = 6'd1;
    x_a = 8'hFF;
    @(posedge clk);
    #1;
    chk("rst_release_a0", int'(if_a0.o_y), 8'h7F);
    chk("rst_release_a1", int'(if_a1.o_y), 8'h7F);

    @(posedge clk);
    #1;
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
